// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one SRAM-like port between instruction fetch and data access.
//   Each side has a req/ok handshake. A winner is chosen in IDLE or RESP, its
//   request is latched (with kseg0/kseg1 translation), driven to the SRAM for
//   one cycle in ISSUE, and completed in RESP with a one-cycle ok pulse and the
//   SRAM read data passed through.
// Parameters
//   FAIR    1: round-robin on contention, 0: data side always wins a tie
//   MAP_EN  1: map 0x8..0xB segments to physical 0x0..0x1F, 0: pass-through
// Ports
//   clk, resetn                     clock, synchronous active-low reset
//   i_req/i_addr -> i_ok/i_rdata    instruction fetch handshake
//   d_req/d_wen/d_addr/d_wdata      data request (d_wen == 0 means read)
//   d_ok/d_rdata                    data completion
//   sram_en/wen/addr/wdata          SRAM command, sram_rdata one cycle later
module sram_port_arbiter #(
  parameter bit FAIR   = 1'b1,
  parameter bit MAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ok,
  output logic [31:0] d_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q, state_d;
  logic        gnt_data_q, gnt_data_d;  // side of the most recent grant (1 = data)
  logic [3:0]  wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic i_elig, d_elig, pick_data;

  function automatic logic [31:0] map_addr(input logic [31:0] va);
    if (MAP_EN && (va[31:30] == 2'b10)) begin
      return {3'b000, va[28:0]};
    end
    return va;
  endfunction

  // The side being completed in RESP still holds its req, so it must not win
  // again off that same request.
  always_comb begin
    i_elig = i_req && !((state_q == StResp) && !gnt_data_q);
    d_elig = d_req && !((state_q == StResp) && gnt_data_q);
    if (i_elig && d_elig) begin
      pick_data = FAIR ? !gnt_data_q : 1'b1;
    end else begin
      pick_data = d_elig;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_data_d = gnt_data_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      StIssue: state_d = StResp;
      StIdle, StResp: begin
        if (i_elig || d_elig) begin
          state_d    = StIssue;
          gnt_data_d = pick_data;
          if (pick_data) begin
            wen_d   = d_wen;
            addr_d  = map_addr(d_addr);
            wdata_d = d_wdata;
          end else begin
            wen_d   = 4'b0000;
            addr_d  = map_addr(i_addr);
            wdata_d = 32'h0;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      gnt_data_q <= 1'b0;
      wen_q      <= 4'b0000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    sram_en    = (state_q == StIssue);
    sram_wen   = sram_en ? wen_q : 4'b0000;
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
    i_ok       = (state_q == StResp) && !gnt_data_q;
    d_ok       = (state_q == StResp) && gnt_data_q;
    // Read data is only meaningful alongside ok; hold it at zero otherwise.
    i_rdata    = i_ok ? sram_rdata : 32'h0;
    d_rdata    = d_ok ? sram_rdata : 32'h0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. Instance 0: FAIR=1, MAP_EN=1.
// Instance 1: FAIR=0, MAP_EN=0. A small SRAM model returns a fixed function
// of the address one cycle after sram_en.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_req [2];
  logic [31:0] i_addr [2];
  logic        i_ok [2];
  logic [31:0] i_rdata [2];
  logic        d_req [2];
  logic [3:0]  d_wen [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic        d_ok [2];
  logic [31:0] d_rdata [2];
  logic        sram_en [2];
  logic [3:0]  sram_wen [2];
  logic [31:0] sram_addr [2];
  logic [31:0] sram_wdata [2];
  logic [31:0] sram_rdata [2];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    sram_port_arbiter #(
      .FAIR   (k == 0),
      .MAP_EN (k == 0)
    ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .i_req      (i_req[k]),
      .i_addr     (i_addr[k]),
      .i_ok       (i_ok[k]),
      .i_rdata    (i_rdata[k]),
      .d_req      (d_req[k]),
      .d_wen      (d_wen[k]),
      .d_addr     (d_addr[k]),
      .d_wdata    (d_wdata[k]),
      .d_ok       (d_ok[k]),
      .d_rdata    (d_rdata[k]),
      .sram_en    (sram_en[k]),
      .sram_wen   (sram_wen[k]),
      .sram_addr  (sram_addr[k]),
      .sram_wdata (sram_wdata[k]),
      .sram_rdata (sram_rdata[k])
    );

    always @(posedge clk) begin
      if (sram_en[k]) sram_rdata[k] <= sram_addr[k] ^ 32'hA5A5_0F0F;
    end
  end

  function automatic logic [31:0] mem_word(input logic [31:0] pa);
    return pa ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One uncontended access: sram_en in cycle 1, ok in cycle 2.
  task automatic access(input int k, input logic isd, input logic [3:0] wen,
                        input logic [31:0] va, input logic [31:0] wd,
                        input logic [31:0] pa, input string nm);
    @(negedge clk);
    if (isd) begin
      d_req[k] = 1'b1; d_wen[k] = wen; d_addr[k] = va; d_wdata[k] = wd;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = va;
    end
    tick();
    chk({nm, ".en"}, 32'(sram_en[k]), 32'd1);
    chk({nm, ".addr"}, sram_addr[k], pa);
    chk({nm, ".wen"}, 32'(sram_wen[k]), isd ? 32'(wen) : 32'd0);
    if (isd) chk({nm, ".wdata"}, sram_wdata[k], wd);
    chk({nm, ".ok_c1"}, {30'd0, i_ok[k], d_ok[k]}, 32'd0);
    tick();
    chk({nm, ".en_c2"}, 32'(sram_en[k]), 32'd0);
    chk({nm, ".ok_c2"}, {30'd0, i_ok[k], d_ok[k]}, isd ? 32'd1 : 32'd2);
    if (isd && wen == 4'b0000) chk({nm, ".rdata"}, d_rdata[k], mem_word(pa));
    if (!isd) chk({nm, ".rdata"}, i_rdata[k], mem_word(pa));
    @(negedge clk);
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
  endtask

  // Simultaneous requests; data_first gives the expected winner.
  task automatic tie(input int k, input logic data_first, input string nm);
    logic [31:0] first_a, second_a;
    first_a  = data_first ? 32'h0000_0200 : 32'h0000_0100;
    second_a = data_first ? 32'h0000_0100 : 32'h0000_0200;
    @(negedge clk);
    i_req[k] = 1'b1; i_addr[k] = 32'h0000_0100;
    d_req[k] = 1'b1; d_addr[k] = 32'h0000_0200; d_wen[k] = 4'b0000;
    tick();
    chk({nm, ".c1_en"}, 32'(sram_en[k]), 32'd1);
    chk({nm, ".c1_addr"}, sram_addr[k], first_a);
    tick();
    chk({nm, ".c2_ok"}, {30'd0, i_ok[k], d_ok[k]}, data_first ? 32'd1 : 32'd2);
    chk({nm, ".c2_rdata"}, data_first ? d_rdata[k] : i_rdata[k], mem_word(first_a));
    @(negedge clk);
    if (data_first) d_req[k] = 1'b0;
    else i_req[k] = 1'b0;
    tick();
    chk({nm, ".c3_en"}, 32'(sram_en[k]), 32'd1);
    chk({nm, ".c3_addr"}, sram_addr[k], second_a);
    chk({nm, ".c3_ok"}, {30'd0, i_ok[k], d_ok[k]}, 32'd0);
    tick();
    chk({nm, ".c4_ok"}, {30'd0, i_ok[k], d_ok[k]}, data_first ? 32'd2 : 32'd1);
    chk({nm, ".c4_rdata"}, data_first ? i_rdata[k] : d_rdata[k], mem_word(second_a));
    @(negedge clk);
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
  endtask

  typedef struct {
    logic        isd;
    logic [3:0]  wen;
    logic [31:0] va;
    logic [31:0] wd;
    logic [31:0] pa_map;
    logic [31:0] pa_pass;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b0, 4'b0000, 32'hBFC0_0000, 32'h0,         32'h1FC0_0000, 32'hBFC0_0000};
    vecs[1] = '{1'b1, 4'b0011, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0000_1004, 32'h0000_1004};
    vecs[2] = '{1'b1, 4'b0000, 32'h9000_0010, 32'h0,         32'h1000_0010, 32'h9000_0010};
    vecs[3] = '{1'b0, 4'b0000, 32'hA000_0000, 32'h0,         32'h0000_0000, 32'hA000_0000};
    vecs[4] = '{1'b1, 4'b1111, 32'hC000_0000, 32'h1234_5678, 32'hC000_0000, 32'hC000_0000};
    vecs[5] = '{1'b0, 4'b0000, 32'h8000_0004, 32'h0,         32'h0000_0004, 32'h8000_0004};
    vecs[6] = '{1'b1, 4'b0000, 32'h7FFF_FFFC, 32'h0,         32'h7FFF_FFFC, 32'h7FFF_FFFC};
    vecs[7] = '{1'b1, 4'b1000, 32'hB000_0008, 32'hCAFE_0001, 32'h1000_0008, 32'hB000_0008};

    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_wen[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    resetn = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      chk("reset.ctl", {25'd0, sram_en[k], sram_wen[k], i_ok[k], d_ok[k]}, 32'd0);
      chk("reset.addr", sram_addr[k], 32'd0);
      chk("reset.wdata", sram_wdata[k], 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;

    for (int v = 0; v < 8; v++) begin
      access(0, vecs[v].isd, vecs[v].wen, vecs[v].va, vecs[v].wd, vecs[v].pa_map,
             $sformatf("vec%0d.map", v));
      access(1, vecs[v].isd, vecs[v].wen, vecs[v].va, vecs[v].wd, vecs[v].pa_pass,
             $sformatf("vec%0d.pass", v));
    end

    // Reset during ISSUE drops the access without an ok.
    @(negedge clk);
    i_req[0] = 1'b1; i_addr[0] = 32'h0000_0040;
    tick();
    chk("rst_mid.issue_en", 32'(sram_en[0]), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    i_req[0] = 1'b0;
    tick();
    chk("rst_mid.ctl", {25'd0, sram_en[0], sram_wen[0], i_ok[0], d_ok[0]}, 32'd0);
    chk("rst_mid.addr", sram_addr[0], 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("rst_mid.no_ok", {29'd0, sram_en[0], i_ok[0], d_ok[0]}, 32'd0);

    // last_grant is INST after reset, so round-robin serves data first.
    tie(0, 1'b1, "tie_fair_after_reset");

    // After a data grant: round-robin favours inst, fixed priority favours data.
    access(0, 1'b1, 4'b0000, 32'h0000_0300, 32'h0, 32'h0000_0300, "pre_tie0");
    access(1, 1'b1, 4'b0000, 32'h0000_0300, 32'h0, 32'h0000_0300, "pre_tie1");
    tie(0, 1'b0, "tie_fair_last_data");
    tie(1, 1'b1, "tie_fixed_data_wins");

    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
